arbitro_troca_endian: RTL and testbench
=======================================

// Module: arbitro_troca_endian
// PURPOSE
//  Shares one 32-bit byte-reordering unit between two requesters (e.g. a DMA reader and a CPU port).
//  Arbitration: round-robin with bounded bursts.
//  Each accepted word is reordered per its mode and registered into a one-entry output stage (valid/ready).
//  Sits between the two producers and a single downstream consumer.
// PARAMETERS
//  MAX_RAJADA  4   max consecutive words granted to one requester before yielding (>=1)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  req0_valid     in   1   requester 0 has a word
//  req0_ready     out  1   requester 0 word accepted this cycle when valid&ready
//  req0_dados     in   32  requester 0 word
//  req0_modo      in   2   requester 0 reorder mode
//  req1_valid     in   1   requester 1 has a word
//  req1_ready     out  1   requester 1 word accepted this cycle when valid&ready
//  req1_dados     in   32  requester 1 word
//  req1_modo      in   2   requester 1 reorder mode
//  saida_valid    out  1   output word valid
//  saida_ready    in   1   downstream accepts output
//  saida_dados    out  32  reordered word
//  saida_origem   out  1   requester index that produced saida_dados
// BEHAVIOUR
//  Modes (B3..B0 = bytes [31:24]..[7:0]):
//    00 passthrough
//    01 full byte reverse (B0B1B2B3)
//    10 byte swap inside each halfword (B2B3B0B1)
//    11 halfword swap (B1B0B3B2)
//  Output stage:
//    load_en = !saida_valid | saida_ready.
//    On an accept: saida_dados/saida_origem load and saida_valid=1.
//    Else if saida_ready: saida_valid=0.
//    Held stable while saida_valid & !saida_ready.
//  FSM states: OCIOSO, SERV0, SERV1. Register cnt (counts accepted words in the current grant) and ultimo.
//  reqN_ready = (estado==SERVN) & load_en. Never both high. Both are 0 in OCIOSO.
//  OCIOSO:
//    no accept
//    only req0_valid -> SERV0; only req1_valid -> SERV1
//    both valid -> SERV of the requester != ultimo
//    cnt=0
//  SERVn, load_en=0: hold state and cnt.
//  SERVn, load_en=1, reqn_valid=1:
//    accept; ultimo=n
//    if cnt==MAX_RAJADA-1: cnt=0; next = SERVm if reqm_valid, else stay SERVn
//    else: cnt++
//  SERVn, load_en=1, reqn_valid=0:
//    cnt=0; next = SERVm if reqm_valid, else OCIOSO
//  Latency:
//    from OCIOSO: valid -> accept 1 cycle later -> saida_valid the cycle after
//    in SERVn: accept -> saida_valid next cycle
//    throughput 1 word/cycle while saida_ready=1
//  Sequencing: no word dropped or duplicated; per-requester order preserved; mode sampled with data at accept.
//  Reset values:
//    estado=OCIOSO, cnt=0, ultimo=1 (req0 wins the first tie)
//    saida_valid=0, saida_dados=0, saida_origem=0, reqN_ready=0
//  Reset mid-operation: the output-stage word is discarded and the burst is abandoned. After release, behaviour is as from power-up.
//  cnt width: $clog2(MAX_RAJADA)+1. MAX_RAJADA=1 gives strict alternation when both requesters are valid.
// STRUCTURE
//  Shared package endian_pkg:
//    mode constants MODO_PASSA/MODO_INV/MODO_MEIA/MODO_TROCA_MEIA
//    FSM state encoding
//  Sub-module troca_bytes (combinational: dados[31:0], modo[1:0] -> saida[31:0]), one instance on the granted requester's data.
//  Top holds the FSM, counter, mux and output register.
// TESTING
//  1. Reset with rst_n=0 -> all outputs 0; release; idle inputs -> saida_valid stays 0.
//  2. req0 0x11223344, modes 00/01/10/11, saida_ready=1
//     -> 0x11223344 / 0x44332211 / 0x22114433 / 0x33441122, origem=0.
//  3. Both requesters valid continuously, MAX_RAJADA=4, saida_ready=1
//     -> origem sequence 0,0,0,0,1,1,1,1,0...; data in per-source order.
//  4. One word in output stage, saida_ready=0 for 5 cycles
//     -> saida_dados stable, reqN_ready=0, no accept; ready=1 -> word consumed once, stream continues.
//  5. req1 alone streaming 10 words -> stays in SERV1 across burst boundaries, 1 word/cycle, no idle gap.
//  6. rst_n pulsed low asynchronously mid-burst -> saida_valid=0 immediately; after release, first tie granted to req0.

Source files
------------

// File: rtl/endian_pkg.sv
// Shared definitions for the byte-reordering arbiter: reorder modes, FSM states, word format.
// Pure declarations, no logic.
package endian_pkg;

  localparam logic [1:0] MODO_PASSA      = 2'b00;
  localparam logic [1:0] MODO_INV        = 2'b01;
  localparam logic [1:0] MODO_MEIA       = 2'b10;
  localparam logic [1:0] MODO_TROCA_MEIA = 2'b11;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    SERV0  = 2'd1,
    SERV1  = 2'd2
  } estado_t;

  typedef struct packed {
    logic [1:0]  modo;
    logic [31:0] dados;
  } palavra_t;

endpackage

// File: rtl/arbitro_troca_endian_troca_bytes.sv
// Combinational 32-bit byte reorder selected by a 2-bit mode; zero latency, no flow control.
// Bytes named B3..B0 from [31:24] down to [7:0].
module troca_bytes
  import endian_pkg::*;
(
  input  logic [31:0] dados_i,
  input  logic [1:0]  modo_i,
  output logic [31:0] saida_o
);

  always_comb begin
    saida_o = dados_i;
    case (modo_i)
      MODO_INV:        saida_o = {dados_i[7:0],   dados_i[15:8],  dados_i[23:16], dados_i[31:24]};
      MODO_MEIA:       saida_o = {dados_i[23:16], dados_i[31:24], dados_i[7:0],   dados_i[15:8]};
      MODO_TROCA_MEIA: saida_o = {dados_i[15:8],  dados_i[7:0],   dados_i[31:24], dados_i[23:16]};
      default:         saida_o = dados_i;
    endcase
  end

endmodule

// File: rtl/arbitro_troca_endian.sv
// Round-robin arbiter (bounded bursts) sharing one byte-reorder unit between two requesters.
// Accept -> saida_valid next cycle; requesters stall while the output stage is full and not drained.
module arbitro_troca_endian
  import endian_pkg::*;
#(
  parameter int MAX_RAJADA = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_dados,
  input  logic [1:0]  req0_modo,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_dados,
  input  logic [1:0]  req1_modo,
  output logic        saida_valid,
  input  logic        saida_ready,
  output logic [31:0] saida_dados,
  output logic        saida_origem
);

  localparam int CW = $clog2(MAX_RAJADA) + 1;
  localparam logic [CW-1:0] CNT_ULT = CW'(MAX_RAJADA - 1);

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ultimo_q, ultimo_d;
  logic          saida_valid_q;
  logic [31:0]   saida_dados_q;
  logic          saida_origem_q;

  logic          load_en, aceita, sel;
  logic          meu_valid, outro_valid;
  estado_t       outro_estado;
  palavra_t      pal;
  logic [31:0]   trocado;

  assign load_en    = !saida_valid_q | saida_ready;
  assign req0_ready = (estado_q == SERV0) & load_en;
  assign req1_ready = (estado_q == SERV1) & load_en;
  assign aceita     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  // Only meaningful in a SERV state; sel is the requester currently holding the grant.
  assign sel          = (estado_q == SERV1);
  assign meu_valid    = sel ? req1_valid : req0_valid;
  assign outro_valid  = sel ? req0_valid : req1_valid;
  assign outro_estado = sel ? SERV0 : SERV1;
  assign pal          = sel ? {req1_modo, req1_dados} : {req0_modo, req0_dados};

  troca_bytes u_troca (
    .dados_i (pal.dados),
    .modo_i  (pal.modo),
    .saida_o (trocado)
  );

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    ultimo_d = ultimo_q;
    case (estado_q)
      OCIOSO: begin
        cnt_d = '0;
        if (req0_valid && req1_valid) estado_d = ultimo_q ? SERV0 : SERV1;
        else if (req0_valid)          estado_d = SERV0;
        else if (req1_valid)          estado_d = SERV1;
      end
      SERV0, SERV1: begin
        if (load_en) begin
          if (meu_valid) begin
            ultimo_d = sel;
            if (cnt_q == CNT_ULT) begin
              cnt_d = '0;
              if (outro_valid) estado_d = outro_estado;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d    = '0;
            estado_d = outro_valid ? outro_estado : OCIOSO;
          end
        end
      end
      default: begin
        estado_d = OCIOSO;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      cnt_q    <= '0;
      ultimo_q <= 1'b1;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      ultimo_q <= ultimo_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saida_valid_q  <= 1'b0;
      saida_dados_q  <= '0;
      saida_origem_q <= 1'b0;
    end else if (aceita) begin
      saida_valid_q  <= 1'b1;
      saida_dados_q  <= trocado;
      saida_origem_q <= sel;
    end else if (saida_ready) begin
      saida_valid_q  <= 1'b0;
    end
  end

  assign saida_valid  = saida_valid_q;
  assign saida_dados  = saida_dados_q;
  assign saida_origem = saida_origem_q;

endmodule

// File: tb/tb_arbitro_troca_endian.sv
// Scoreboard bench for arbitro_troca_endian: randomized and directed streams against a byte-permutation model.
module tb_arbitro_troca_endian;

  localparam int MAXR = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_dados, req1_dados, saida_dados;
  logic [1:0]  req0_modo, req1_modo;
  logic        saida_valid, saida_ready, saida_origem;

  always #5 clk = ~clk;

  arbitro_troca_endian #(.MAX_RAJADA(MAXR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_dados   (req0_dados),
    .req0_modo    (req0_modo),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_dados   (req1_dados),
    .req1_modo    (req1_modo),
    .saida_valid  (saida_valid),
    .saida_ready  (saida_ready),
    .saida_dados  (saida_dados),
    .saida_origem (saida_origem)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          acc_total = 0;
  logic [33:0] stim0[$], stim1[$];
  logic [31:0] exp0[$], exp1[$];
  bit          orig_log[$];
  int          out_cyc[$];
  logic [31:0] dat_log[$];
  bit          en0 = 0, en1 = 0, rand_valid = 0, rand_ready = 0, ready_force = 0;
  bit          last_orig = 0;
  logic [31:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Output byte i is taken from source byte src(i), a per-mode permutation of indices.
  function automatic logic [31:0] ref_troca(input logic [31:0] d, input logic [1:0] m);
    logic [31:0] r;
    int src;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      case (m)
        2'd0:    src = i;
        2'd1:    src = 3 - i;
        2'd2:    src = i ^ 1;
        default: src = i ^ 2;
      endcase
      r[8*i +: 8] = d[8*src +: 8];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic push_rand(input bit src, input int n);
    for (int i = 0; i < n; i++) begin
      if (src) stim1.push_back({2'($urandom_range(0, 3)), 32'($urandom)});
      else     stim0.push_back({2'($urandom_range(0, 3)), 32'($urandom)});
    end
  endtask

  task automatic drain(input int budget, input string nm);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (stim0.size() == 0 && stim1.size() == 0 && exp0.size() == 0 && exp1.size() == 0);
    end
    if (!done) fail_now({nm, "_drain_timeout"});
    @(negedge clk);
  endtask

  // Driver: handshakes observed at the negedge, new inputs applied just after the posedge.
  initial begin : driver
    logic [33:0] w;
    req0_valid = 0; req1_valid = 0; req0_dados = '0; req1_dados = '0;
    req0_modo = '0; req1_modo = '0; saida_ready = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (req0_valid && req0_ready) begin
          w = stim0.pop_front();
          exp0.push_back(ref_troca(w[31:0], w[33:32]));
          acc_total++;
        end
        if (req1_valid && req1_ready) begin
          w = stim1.pop_front();
          exp1.push_back(ref_troca(w[31:0], w[33:32]));
          acc_total++;
        end
      end
      @(posedge clk);
      #1;
      w = (stim0.size() > 0) ? stim0[0] : 34'($urandom);
      req0_valid = en0 && stim0.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0);
      req0_dados = w[31:0];
      req0_modo  = w[33:32];
      w = (stim1.size() > 0) ? stim1[0] : 34'($urandom);
      req1_valid = en1 && stim1.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0);
      req1_dados = w[31:0];
      req1_modo  = w[33:32];
      saida_ready = rand_ready ? ($urandom_range(0, 2) != 0) : ready_force;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("ready_exclusive", 32'(req0_ready & req1_ready), 32'd0);
      if (saida_valid && saida_ready) begin
        if (saida_origem) begin
          if (exp1.size() == 0) fail_now("unexpected_word_src1");
          else begin mon_e = exp1.pop_front(); chk("dados_src1", saida_dados, mon_e); end
        end else begin
          if (exp0.size() == 0) fail_now("unexpected_word_src0");
          else begin mon_e = exp0.pop_front(); chk("dados_src0", saida_dados, mon_e); end
        end
        orig_log.push_back(saida_origem);
        out_cyc.push_back(cyc);
        dat_log.push_back(saida_dados);
        last_orig = saida_origem;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic [31:0] held, const_exp[4];
    int          acc_before, nsz;
    bit          first;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_saida_valid", 32'(saida_valid), 32'd0);
    chk("rst_saida_dados", saida_dados, 32'd0);
    chk("rst_saida_origem", 32'(saida_origem), 32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #3; rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_saida_valid", 32'(saida_valid), 32'd0);
    end

    // Four modes on one word, with first-accept latency from idle
    ready_force = 1;
    for (int m = 0; m < 4; m++) stim0.push_back({2'(m), 32'h11223344});
    const_exp[0] = 32'h11223344; const_exp[1] = 32'h44332211;
    const_exp[2] = 32'h22114433; const_exp[3] = 32'h33441122;
    dat_log.delete(); orig_log.delete();
    @(negedge clk);
    en0 = 1;
    @(negedge clk);
    chk("lat_idle_req0_ready", 32'(req0_ready), 32'd0);
    @(negedge clk);
    chk("lat_serv_req0_ready", 32'(req0_ready), 32'd1);
    chk("lat_serv_saida_valid", 32'(saida_valid), 32'd0);
    @(negedge clk);
    chk("lat_out_saida_valid", 32'(saida_valid), 32'd1);
    drain(100, "modes");
    en0 = 0;
    if (dat_log.size() != 4) fail_now("modes_word_count");
    else for (int k = 0; k < 4; k++) begin
      chk("modes_dados", dat_log[k], const_exp[k]);
      chk("modes_origem", 32'(orig_log[k]), 32'd0);
    end

    // Both requesters continuously valid: bursts of MAXR alternate
    push_rand(0, 12); push_rand(1, 12);
    orig_log.delete();
    first = !last_orig;
    en0 = 1; en1 = 1;
    drain(200, "burst");
    en0 = 0; en1 = 0;
    chk("burst_word_count", 32'(orig_log.size()), 32'd24);
    for (int k = 0; k < orig_log.size() && k < 24; k++)
      chk("burst_origem_seq", 32'(orig_log[k]), 32'(first ^ ((k / MAXR) % 2)));

    // Output stage stalled with saida_ready low
    ready_force = 0;
    push_rand(0, 3);
    dat_log.delete();
    en0 = 1;
    held = '0;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = saida_valid;
      end
      if (!seen) fail_now("stall_wait_valid");
      held = saida_dados;
    end
    acc_before = acc_total;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_saida_valid", 32'(saida_valid), 32'd1);
      chk("stall_dados_stable", saida_dados, held);
      chk("stall_req0_ready", 32'(req0_ready), 32'd0);
    end
    chk("stall_no_accept", 32'(acc_total), 32'(acc_before));
    ready_force = 1;
    drain(100, "stall");
    en0 = 0;
    chk("stall_word_count", 32'(dat_log.size()), 32'd3);

    // Single requester streams across burst boundaries without gaps
    push_rand(1, 10);
    out_cyc.delete(); orig_log.delete();
    en1 = 1;
    drain(200, "solo");
    en1 = 0;
    chk("solo_word_count", 32'(out_cyc.size()), 32'd10);
    for (int k = 0; k + 1 < out_cyc.size(); k++) begin
      chk("solo_gap", 32'(out_cyc[k+1] - out_cyc[k]), 32'd1);
      chk("solo_origem", 32'(orig_log[k]), 32'd1);
    end

    // Random valid/ready traffic
    push_rand(0, 30); push_rand(1, 30);
    rand_valid = 1; rand_ready = 1;
    en0 = 1; en1 = 1;
    drain(3000, "random");
    rand_valid = 0; rand_ready = 0;
    en0 = 0; en1 = 0;

    // Asynchronous reset in the middle of a burst
    ready_force = 1;
    push_rand(0, 8); push_rand(1, 8);
    en0 = 1; en1 = 1;
    repeat (6) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    chk("midrst_saida_valid", 32'(saida_valid), 32'd0);
    chk("midrst_req0_ready", 32'(req0_ready), 32'd0);
    chk("midrst_req1_ready", 32'(req1_ready), 32'd0);
    exp0.delete(); exp1.delete();
    repeat (2) @(posedge clk);
    #3; rst_n = 1'b1;
    orig_log.delete();
    drain(300, "postrst");
    en0 = 0; en1 = 0;
    nsz = orig_log.size();
    if (nsz == 0) fail_now("postrst_no_output");
    else chk("postrst_first_tie", 32'(orig_log[0]), 32'd0);
    chk("final_exp0_empty", 32'(exp0.size()), 32'd0);
    chk("final_exp1_empty", 32'(exp1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
